conv_ctrl_fsm: RTL and testbench
================================

// Module: conv_ctrl_fsm
// PURPOSE
//   Single-clock control FSM for the convolution PE array. Scans a square IFM
//   one line at a time, and walks channels and filters.
//   Drives per-row line-buffer write enables and PE-row read enables, plus the
//   psum clear/accumulate controls, OFM-valid and done for the whole layer.
//   Generalises the earlier PE controller: parametrised stride, in_valid stall
//   handshake, synchronous abort, explicit psum/OFM control.
// PARAMETERS
//   KERNEL_SIZE  4  kernel height/width K (>=1)
//   IFM_SIZE     9  input feature map height/width; must be >= K
//   STRIDE       1  window stride; (IFM_SIZE-K) % STRIDE == 0 (elaboration $error)
//   CI           3  input channels per filter
//   CO           4  number of filters
//   CNT_W        8  counter width; must hold max(IFM_SIZE,CI,CO)
// PORTS
//   clk1        in   1       clock
//   rst_n       in   1       asynchronous reset, active-low
//   start_conv  in   1       1-cycle start pulse; ignored unless state==IDLE
//   abort       in   1       synchronous abort; returns to IDLE, no done pulse
//   in_valid    in   1       one IFM pixel present this cycle; 0 = stall
//   wr_en       out  K       line-buffer row i write enable
//   rd_en       out  K       PE row i read enable (all rows equal when window valid)
//   wr_clr      out  1       line-buffer write pointer clear (end of line)
//   rd_clr      out  1       line-buffer read pointer clear (end of line)
//   psum_clr    out  1       window on channel 0: overwrite psum
//   psum_acc    out  1       window on channel >0: accumulate psum
//   ofm_valid   out  1       window on last channel: psum is a final OFM pixel
//   busy        out  1       state != IDLE
//   done        out  1       1-cycle pulse after the last pixel of the last filter
//   cnt_index/cnt_line/cnt_channel/cnt_filter  out  CNT_W  current position
// BEHAVIOUR
//   Reset: state=IDLE; all counters 0; every output 0.
//   States: IDLE->COMPUTE on start_conv.
//     COMPUTE: each in_valid cycle advances cnt_index 0..IFM_SIZE-1.
//     Last column ->END_ROW.
//     END_ROW (1 bubble cycle): wr_clr=rd_clr=1; cnt_index=0, cnt_line++.
//       Returns to COMPUTE, or on the last line goes to END_CHANNEL.
//     END_CHANNEL (1 cycle): cnt_line=0, cnt_channel++.
//       Returns to COMPUTE, or on the last channel goes to END_FILTER.
//     END_FILTER (1 cycle): cnt_channel=0, cnt_filter++.
//       Returns to COMPUTE, or on the last filter goes to DONE.
//     DONE (1 cycle): done=1 -> IDLE; all counters 0.
//   Enables are registered: 1-cycle latency from the accepted pixel
//   (COMPUTE && in_valid), evaluated on that pixel's counter values:
//     wr_en[i] = (cnt_line >= i)
//     win      = cnt_line >= K-1 && (cnt_line-(K-1))%STRIDE==0 &&
//                cnt_index>= K-1 && (cnt_index-(K-1))%STRIDE==0
//     rd_en    = {K{win}}
//     psum_clr = win && cnt_channel==0
//     psum_acc = win && cnt_channel!=0
//     ofm_valid= win && cnt_channel==CI-1
//   in_valid=0 in COMPUTE: counters hold; next-cycle enables all 0.
//   END_* and DONE cycles never assert wr_en/rd_en.
//   Per filter: OFM pixels = ((IFM_SIZE-K)/STRIDE+1)^2.
//   start_conv while busy: ignored.
//   abort: wins over every other event; next cycle IDLE with counters and
//     outputs 0, done stays 0.
//   abort and start_conv together in IDLE: stay IDLE.
//   rst_n mid-operation: immediate return to reset values.
//   Wrap rule: counters compare against PARAM-1 (no overflow); CNT_W truncation
//   never occurs given the parameter check.
// STRUCTURE
//   conv_ctrl_pkg: state_t enum {IDLE,COMPUTE,END_ROW,END_CHANNEL,END_FILTER,DONE}
//     and function ofm_size(ifm,k,stride).
//   Sub-module conv_axis_counter: wrap counter with enable and terminal flag,
//     plus stride-phase flag. Used for index/line; channel/filter counters inline.
//   One state register; next-state logic and output registers in clk1 domain only.
// TESTING
//   1) K=4,IFM=9,S=1,CI=1,CO=1, in_valid=1 always -> 36 ofm_valid; done exactly
//      once, 9*9+9 cycles after start (+ END_CHANNEL/END_FILTER/DONE overhead).
//   2) K=3,IFM=9,S=2 -> 16 ofm_valid per filter; rd_en only at index/line 2,4,6,8.
//   3) CI=3: psum_clr on ch0, psum_acc on ch1/2, ofm_valid only on ch2 windows.
//   4) Random in_valid gaps -> same enable sequence as test 1 with gaps inserted;
//      no enable during stall.
//   5) abort mid-line 5 -> next cycle IDLE, all outputs 0, no done;
//      a new start_conv completes normally.
//   6) rst_n low during END_ROW -> all outputs 0 asynchronously;
//      start_conv while busy has no effect on the counters.

Source files
------------

// File: rtl/conv_ctrl_fsm_pkg.sv
// Shared types and helpers for the convolution PE-array controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COMPUTE,
        END_ROW,
        END_CHANNEL,
        END_FILTER,
        DONE
    } state_t;

    // Output feature map width/height for a square IFM and square kernel.
    function automatic int ofm_size(input int ifm, input int k, input int stride);
        return (ifm - k) / stride + 1;
    endfunction

endpackage

// File: rtl/conv_ctrl_fsm_if.sv
// Control bundle between the pixel source / PE array and the conv controller.
// Latency: n/a (wiring only).
// Backpressure: in_valid low stalls the scan; no ready is returned.
interface conv_ctrl_fsm_if
    import conv_ctrl_pkg::*;
#(
    parameter int K     = 4,
    parameter int CNT_W = 8
);
    logic             start_conv;
    logic             abort;
    logic             in_valid;
    logic [K-1:0]     wr_en;
    logic [K-1:0]     rd_en;
    logic             wr_clr;
    logic             rd_clr;
    logic             psum_clr;
    logic             psum_acc;
    logic             ofm_valid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cnt_index;
    logic [CNT_W-1:0] cnt_line;
    logic [CNT_W-1:0] cnt_channel;
    logic [CNT_W-1:0] cnt_filter;

    modport master (
        output start_conv, abort, in_valid,
        input  wr_en, rd_en, wr_clr, rd_clr, psum_clr, psum_acc, ofm_valid,
        input  busy, done, cnt_index, cnt_line, cnt_channel, cnt_filter
    );

    modport slave (
        input  start_conv, abort, in_valid,
        output wr_en, rd_en, wr_clr, rd_clr, psum_clr, psum_acc, ofm_valid,
        output busy, done, cnt_index, cnt_line, cnt_channel, cnt_filter
    );
endinterface

// File: rtl/conv_ctrl_fsm_axis_counter.sv
// Wrapping position counter for one scan axis (column or line) with stride-phase decode.
// Latency: count updates one cycle after en; last/phase decode the current count.
// Backpressure: holds while en is low; clr wins over en.
module conv_axis_counter
    import conv_ctrl_pkg::*;
#(
    parameter int LIMIT  = 9,
    parameter int K      = 4,
    parameter int STRIDE = 1,
    parameter int W      = 8
) (
    input  logic         clk1,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         last,
    output logic         phase
);

    logic [31:0] cnt_ext;

    // Count 0..LIMIT-1 and wrap back to zero after the terminal value.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + W'(1);
        end
    end

    assign last    = (cnt == W'(LIMIT - 1));
    assign cnt_ext = 32'(cnt);
    // High where a kernel window ends on this axis: past the first K-1 and on the stride grid.
    assign phase   = (cnt_ext >= 32'(K - 1)) &&
                     (((cnt_ext - 32'(K - 1)) % 32'(STRIDE)) == 32'd0);

endmodule

// File: rtl/conv_ctrl_fsm.sv
// Layer scan controller: walks pixels, lines, channels and filters; drives line-buffer/PE/psum controls.
// Latency: enables are registered, 1 cycle after the accepted pixel; state decodes are immediate.
// Backpressure: in_valid low stalls the scan (counters hold, enables drop); abort returns to IDLE.
module conv_ctrl_fsm
    import conv_ctrl_pkg::*;
#(
    parameter int KERNEL_SIZE = 4,
    parameter int IFM_SIZE    = 9,
    parameter int STRIDE      = 1,
    parameter int CI          = 3,
    parameter int CO          = 4,
    parameter int CNT_W       = 8
) (
    input logic            clk1,
    input logic            rst_n,
    conv_ctrl_fsm_if.slave bus
);

    if (KERNEL_SIZE < 1 || IFM_SIZE < KERNEL_SIZE || STRIDE < 1) begin : g_bad_size
        $error("conv_ctrl_fsm: need KERNEL_SIZE>=1, IFM_SIZE>=KERNEL_SIZE, STRIDE>=1");
    end
    if ((ofm_size(IFM_SIZE, KERNEL_SIZE, STRIDE) - 1) * STRIDE + KERNEL_SIZE != IFM_SIZE) begin : g_bad_stride
        $error("conv_ctrl_fsm: (IFM_SIZE-KERNEL_SIZE) must be a multiple of STRIDE");
    end
    if (IFM_SIZE >= (1 << CNT_W) || CI >= (1 << CNT_W) || CO >= (1 << CNT_W)) begin : g_bad_width
        $error("conv_ctrl_fsm: CNT_W too narrow for IFM_SIZE/CI/CO");
    end

    state_t                 state;
    state_t                 state_nxt;
    logic                   accept;
    logic                   win;
    logic [CNT_W-1:0]       idx_cnt;
    logic [CNT_W-1:0]       line_cnt;
    logic [CNT_W-1:0]       ch_cnt;
    logic [CNT_W-1:0]       flt_cnt;
    logic                   idx_last;
    logic                   idx_phase;
    logic                   line_last;
    logic                   line_phase;
    logic                   ch_last;
    logic                   flt_last;
    logic [KERNEL_SIZE-1:0] wr_nxt;
    logic [KERNEL_SIZE-1:0] wr_q;
    logic [KERNEL_SIZE-1:0] rd_q;
    logic                   psum_clr_q;
    logic                   psum_acc_q;
    logic                   ofm_q;
    logic                   busy_c;
    logic                   done_c;
    logic                   row_clr_c;

    // A pixel is consumed only in COMPUTE; abort discards it.
    assign accept   = (state == COMPUTE) && bus.in_valid && !bus.abort;
    assign ch_last  = (ch_cnt == CNT_W'(CI - 1));
    assign flt_last = (flt_cnt == CNT_W'(CO - 1));

    conv_axis_counter #(
        .LIMIT (IFM_SIZE),
        .K     (KERNEL_SIZE),
        .STRIDE(STRIDE),
        .W     (CNT_W)
    ) u_index (
        .clk1 (clk1),
        .rst_n(rst_n),
        .clr  (bus.abort),
        .en   (accept),
        .cnt  (idx_cnt),
        .last (idx_last),
        .phase(idx_phase)
    );

    conv_axis_counter #(
        .LIMIT (IFM_SIZE),
        .K     (KERNEL_SIZE),
        .STRIDE(STRIDE),
        .W     (CNT_W)
    ) u_line (
        .clk1 (clk1),
        .rst_n(rst_n),
        .clr  (bus.abort),
        .en   (state == END_ROW),
        .cnt  (line_cnt),
        .last (line_last),
        .phase(line_phase)
    );

    // Channel and filter counters step once per END_CHANNEL / END_FILTER and wrap at the end.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            ch_cnt  <= '0;
            flt_cnt <= '0;
        end else if (bus.abort) begin
            ch_cnt  <= '0;
            flt_cnt <= '0;
        end else begin
            if (state == END_CHANNEL) ch_cnt  <= ch_last  ? '0 : ch_cnt + CNT_W'(1);
            if (state == END_FILTER)  flt_cnt <= flt_last ? '0 : flt_cnt + CNT_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: abort overrides everything, start is honoured only from IDLE.
    always_comb begin
        state_nxt = state;
        if (bus.abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:        if (bus.start_conv) state_nxt = COMPUTE;
                COMPUTE:     if (bus.in_valid && idx_last) state_nxt = END_ROW;
                END_ROW:     state_nxt = line_last ? END_CHANNEL : COMPUTE;
                END_CHANNEL: state_nxt = ch_last ? END_FILTER : COMPUTE;
                END_FILTER:  state_nxt = flt_last ? DONE : COMPUTE;
                DONE:        state_nxt = IDLE;
                default:     state_nxt = IDLE;
            endcase
        end
    end

    // State decodes: busy, done pulse and end-of-line pointer clears.
    always_comb begin
        busy_c    = (state != IDLE);
        done_c    = (state == DONE);
        row_clr_c = (state == END_ROW);
    end

    // Window / row-write decode on the position of the pixel being accepted.
    always_comb begin
        win = line_phase && idx_phase;
        for (int i = 0; i < KERNEL_SIZE; i++) begin
            wr_nxt[i] = accept && (line_cnt >= CNT_W'(i));
        end
    end

    // Register the per-pixel enables; non-accept cycles (stall, bubbles, abort) yield zeros.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            wr_q       <= '0;
            rd_q       <= '0;
            psum_clr_q <= 1'b0;
            psum_acc_q <= 1'b0;
            ofm_q      <= 1'b0;
        end else begin
            wr_q       <= wr_nxt;
            rd_q       <= {KERNEL_SIZE{accept && win}};
            psum_clr_q <= accept && win && (ch_cnt == '0);
            psum_acc_q <= accept && win && (ch_cnt != '0);
            ofm_q      <= accept && win && ch_last;
        end
    end

    assign bus.wr_en       = wr_q;
    assign bus.rd_en       = rd_q;
    assign bus.psum_clr    = psum_clr_q;
    assign bus.psum_acc    = psum_acc_q;
    assign bus.ofm_valid   = ofm_q;
    assign bus.wr_clr      = row_clr_c;
    assign bus.rd_clr      = row_clr_c;
    assign bus.busy        = busy_c;
    assign bus.done        = done_c;
    assign bus.cnt_index   = idx_cnt;
    assign bus.cnt_line    = line_cnt;
    assign bus.cnt_channel = ch_cnt;
    assign bus.cnt_filter  = flt_cnt;

endmodule

// File: tb/tb_conv_ctrl_fsm.sv
// Bench for conv_ctrl_fsm: two configurations, scoreboarded per-pixel enables.
// Latency: expects enables one cycle after each accepted pixel.
// Backpressure: exercises in_valid stalls, abort and asynchronous reset.
module tb_conv_ctrl_fsm;

    localparam int IFM = 9;

    typedef struct packed {
        logic [3:0] wr;
        logic [3:0] rd;
        logic       clr;
        logic       acc;
        logic       ov;
    } obs_t;

    typedef struct packed {
        logic [7:0] idx;
        logic [7:0] line;
        logic [7:0] ch;
        logic [7:0] flt;
        logic       wclr;
        logic       rclr;
        logic       busy;
        logic       done;
    } stat_t;

    logic clk1  = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   ofm_cnt [2] = '{0, 0};
    int   done_cnt[2] = '{0, 0};
    obs_t qa[$];
    obs_t qb[$];

    always #5 clk1 = ~clk1;

    // a: K=4, stride 1, 3 channels, 2 filters.  b: K=3, stride 2, 1 channel, 1 filter.
    conv_ctrl_fsm_if #(.K(4), .CNT_W(8)) ia ();
    conv_ctrl_fsm_if #(.K(3), .CNT_W(8)) ib ();

    conv_ctrl_fsm #(
        .KERNEL_SIZE(4), .IFM_SIZE(IFM), .STRIDE(1), .CI(3), .CO(2), .CNT_W(8)
    ) dut_a (
        .clk1 (clk1),
        .rst_n(rst_n),
        .bus  (ia)
    );

    conv_ctrl_fsm #(
        .KERNEL_SIZE(3), .IFM_SIZE(IFM), .STRIDE(2), .CI(1), .CO(1), .CNT_W(8)
    ) dut_b (
        .clk1 (clk1),
        .rst_n(rst_n),
        .bus  (ib)
    );

    function automatic obs_t get_obs(input int sel);
        obs_t o;
        o = '0;
        if (sel == 0) begin
            o.wr = ia.wr_en; o.rd = ia.rd_en;
            o.clr = ia.psum_clr; o.acc = ia.psum_acc; o.ov = ia.ofm_valid;
        end else begin
            o.wr = {1'b0, ib.wr_en}; o.rd = {1'b0, ib.rd_en};
            o.clr = ib.psum_clr; o.acc = ib.psum_acc; o.ov = ib.ofm_valid;
        end
        return o;
    endfunction

    function automatic stat_t get_stat(input int sel);
        stat_t s;
        if (sel == 0) begin
            s.idx = ia.cnt_index; s.line = ia.cnt_line; s.ch = ia.cnt_channel; s.flt = ia.cnt_filter;
            s.wclr = ia.wr_clr; s.rclr = ia.rd_clr; s.busy = ia.busy; s.done = ia.done;
        end else begin
            s.idx = ib.cnt_index; s.line = ib.cnt_line; s.ch = ib.cnt_channel; s.flt = ib.cnt_filter;
            s.wclr = ib.wr_clr; s.rclr = ib.rd_clr; s.busy = ib.busy; s.done = ib.done;
        end
        return s;
    endfunction

    // Expected enables for a pixel at (line l, column x) on channel c.
    function automatic obs_t model(input int sel, input int l, input int x, input int c);
        obs_t e;
        int   k;
        int   s;
        int   ci;
        bit   win;
        e  = '0;
        k  = (sel == 0) ? 4 : 3;
        s  = (sel == 0) ? 1 : 2;
        ci = (sel == 0) ? 3 : 1;
        win = (l >= k - 1) && ((l - (k - 1)) % s == 0) && (x >= k - 1) && ((x - (k - 1)) % s == 0);
        for (int i = 0; i < k; i++) begin
            e.wr[i] = (l >= i);
            e.rd[i] = win;
        end
        e.clr = win && (c == 0);
        e.acc = win && (c != 0);
        e.ov  = win && (c == ci - 1);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
        end
    endtask

    task automatic check_idle(input int sel, input string nm);
        chk({nm, "_obs"}, 64'(get_obs(sel)), 64'd0);
        chk({nm, "_stat"}, 64'(get_stat(sel)), 64'd0);
    endtask

    task automatic setv(input int sel, input bit st, input bit ab, input bit iv);
        if (sel == 0) begin
            ia.start_conv = st; ia.abort = ab; ia.in_valid = iv;
        end else begin
            ib.start_conv = st; ib.abort = ab; ib.in_valid = iv;
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    // mode 0: full layer; 1: abort at line 5 column 4; 2: async reset while in END_ROW of line 0.
    task automatic run(input int sel, input int gap, input int mode, input bit poke);
        int    ci;
        int    co;
        int    n;
        int    stalls;
        int    bound;
        obs_t  e;
        stat_t es;
        stat_t st;
        ci = (sel == 0) ? 3 : 1;
        co = (sel == 0) ? 2 : 1;
        n = 0;
        stalls = 0;
        setv(sel, 1'b1, 1'b0, 1'b0);
        tick();
        setv(sel, 1'b0, 1'b0, 1'b0);
        for (int f = 0; f < co; f++) begin
            for (int c = 0; c < ci; c++) begin
                for (int l = 0; l < IFM; l++) begin
                    for (int x = 0; x < IFM; x++) begin
                        if (gap > 0 && $urandom_range(0, 99) < gap) begin
                            setv(sel, 1'b0, 1'b0, 1'b0);
                            tick(); n++; stalls++;
                        end
                        if (mode == 1 && f == 0 && c == 0 && l == 5 && x == 4) begin
                            setv(sel, 1'b0, 1'b1, 1'b1);
                            tick();
                            setv(sel, 1'b0, 1'b0, 1'b0);
                            check_idle(sel, "abort");
                            return;
                        end
                        e = model(sel, l, x, c);
                        if (sel == 0) qa.push_back(e);
                        else          qb.push_back(e);
                        setv(sel, poke && l == 1 && x == 3, 1'b0, 1'b1);
                        tick(); n++;
                        es.idx  = (x == IFM - 1) ? 8'd0 : 8'(x + 1);
                        es.line = 8'(l);
                        es.ch   = 8'(c);
                        es.flt  = 8'(f);
                        es.wclr = (x == IFM - 1);
                        es.rclr = (x == IFM - 1);
                        es.busy = 1'b1;
                        es.done = 1'b0;
                        chk("pos", 64'(get_stat(sel)), 64'(es));
                        if (x == IFM - 1) begin
                            if (mode == 2) begin
                                setv(sel, 1'b0, 1'b0, 1'b0);
                                @(negedge clk1);
                                #1 rst_n = 1'b0;
                                #1 check_idle(sel, "rst_async");
                                #2 rst_n = 1'b1;
                                tick();
                                return;
                            end
                            // Source keeps in_valid high through the bubbles; it must be ignored.
                            setv(sel, 1'b0, 1'b0, 1'b1);
                            tick(); n++;
                            if (l == IFM - 1) begin
                                tick(); n++;
                                if (c == ci - 1) begin
                                    tick(); n++;
                                end
                            end
                        end
                    end
                end
            end
        end
        setv(sel, 1'b0, 1'b0, 1'b0);
        bound = 0;
        st = get_stat(sel);
        while (st.done !== 1'b1 && bound < 8) begin
            tick(); n++; bound++;
            st = get_stat(sel);
        end
        chk("done_cycle", 64'(n), 64'(co * (ci * (IFM * (IFM + 1) + 1) + 1) + stalls));
        tick();
        check_idle(sel, "after_done");
    endtask

    // Scoreboard monitor: wr_en[0] marks the output of every accepted pixel.
    initial begin : monitor
        obs_t  o;
        obs_t  e;
        stat_t st;
        #30;
        forever begin
            @(negedge clk1);
            for (int s = 0; s < 2; s++) begin
                o  = get_obs(s);
                st = get_stat(s);
                if (o.ov)    ofm_cnt[s]++;
                if (st.done) done_cnt[s]++;
                if (o.wr[0]) begin
                    if ((s == 0 && qa.size() == 0) || (s == 1 && qb.size() == 0)) begin
                        total++;
                        bad++;
                        $display("FAIL sb_unexpected dut=%0d t=%0t got=%h exp=none", s, $time, o);
                    end else begin
                        if (s == 0) e = qa.pop_front();
                        else        e = qb.pop_front();
                        chk((s == 0) ? "sb_a" : "sb_b", 64'(o), 64'(e));
                    end
                end else begin
                    chk((s == 0) ? "sb_idle_a" : "sb_idle_b", 64'(o), 64'd0);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        setv(0, 1'b0, 1'b0, 1'b0);
        setv(1, 1'b0, 1'b0, 1'b0);
        #2  rst_n = 1'b0;
        #20 rst_n = 1'b1;
        tick();
        check_idle(0, "reset_a");
        check_idle(1, "reset_b");

        // start and abort together in IDLE: stay idle
        setv(0, 1'b1, 1'b1, 1'b0);
        tick();
        setv(0, 1'b0, 1'b0, 1'b0);
        check_idle(0, "abort_start_idle");

        run(1, 0, 0, 1'b1);   // K=3 stride 2, start pulses while busy
        run(0, 0, 0, 1'b0);   // K=4 stride 1, 3 channels, 2 filters
        run(0, 0, 1, 1'b0);   // abort mid line 5
        run(0, 30, 0, 1'b1);  // restart after abort, random stalls
        run(0, 0, 2, 1'b0);   // reset during END_ROW
        tick();
        tick();

        // a: 2 complete layers x 2 filters x 6x6 windows; b: 4x4 windows
        chk("ofm_a", 64'(ofm_cnt[0]), 64'd144);
        chk("ofm_b", 64'(ofm_cnt[1]), 64'd16);
        chk("done_a", 64'(done_cnt[0]), 64'd2);
        chk("done_b", 64'(done_cnt[1]), 64'd1);
        chk("q_a_empty", 64'(qa.size()), 64'd0);
        chk("q_b_empty", 64'(qb.size()), 64'd0);
        check_idle(0, "end_a");
        check_idle(1, "end_b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
